// File: rtl/fir_cfg_pkg.sv
// +------------------------------------------------------------------+
// | fir_cfg_pkg : register map, bit positions and FSM states for     |
// |               the FIR coefficient controller.                    |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

package fir_cfg_pkg;

  localparam int c_reg_ctrl    = 'h000;
  localparam int c_reg_status  = 'h001;
  localparam int c_reg_ntaps   = 'h002;
  localparam int c_reg_chksum  = 'h003;
  localparam int c_shadow_base = 'h100;

  localparam int c_ctrl_en     = 0;
  localparam int c_ctrl_commit = 1;
  localparam int c_ctrl_irq_en = 2;

  localparam int c_stat_busy   = 0;
  localparam int c_stat_done   = 1;
  localparam int c_stat_pend   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_COPY = 2'd2,
    S_DONE = 2'd3
  } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/fir_coef_shadow.sv
// +------------------------------------------------------------------+
// | fir_coef_shadow : byte-enabled shadow coefficient bank with a    |
// |                   registered bus read port and a combinational   |
// |                   copy read port.                                |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
`default_nettype none

module fir_coef_shadow #(
  parameter int N_TAPS = 16,
  parameter int COEF_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_we,
  input  logic [$clog2(N_TAPS)-1:0] i_widx,
  input  logic [31:0]               i_wdata,
  input  logic [3:0]                i_be,
  input  logic                      i_re,
  input  logic [$clog2(N_TAPS)-1:0] i_ridx,
  output logic [COEF_W-1:0]         o_rdata,
  input  logic [$clog2(N_TAPS)-1:0] i_cidx,
  output logic [COEF_W-1:0]         o_cdata
);

  logic [COEF_W-1:0] r_mem [N_TAPS];
  logic [COEF_W-1:0] w_bmask;
  logic              w_unused_wdata;

  for (genvar b = 0; b < COEF_W; b++) begin : g_mask
    assign w_bmask[b] = i_be[b/8];
  end

  // Bits above COEF_W are dropped; the bus reads them back as 0.
  assign w_unused_wdata = ^i_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TAPS; t++) r_mem[t] <= '0;
      o_rdata <= '0;
    end else begin
      if (i_we)
        r_mem[i_widx] <= (r_mem[i_widx] & ~w_bmask) | (i_wdata[COEF_W-1:0] & w_bmask);
      if (i_re)
        o_rdata <= r_mem[i_ridx];
    end
  end

  assign o_cdata = r_mem[i_cidx];

endmodule

`default_nettype wire

// File: rtl/fir_coef_ctrl.sv
// +------------------------------------------------------------------+
// | fir_coef_ctrl : Avalon-MM coefficient controller; commits the    |
// |                 shadow bank to the FIR on a sample boundary.     |
// |                 Optional checksum: FIR_COEF_CHKSUM_EN.           |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
`default_nettype none

module fir_coef_ctrl
  import fir_cfg_pkg::*;
#(
  parameter int N_TAPS = 16,
  parameter int COEF_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [ADDR_W-1:0]         avs_address,
  input  logic                      avs_read,
  input  logic                      avs_write,
  input  logic [31:0]               avs_writedata,
  input  logic [3:0]                avs_byteenable,
  output logic                      avs_waitrequest,
  output logic [31:0]               avs_readdata,
  output logic                      avs_readdatavalid,
  input  logic                      sample_strobe,
  output logic                      coef_we,
  output logic [$clog2(N_TAPS)-1:0] coef_idx,
  output logic [COEF_W-1:0]         coef_data,
  output logic                      fir_enable,
  output logic                      irq
);

  localparam int IDX_W = $clog2(N_TAPS);

  fsm_state_t         r_state, w_next;
  logic [IDX_W-1:0]   r_cnt;
  logic               r_en, r_irq_en, r_done;
  logic               r_rsh;
  logic [31:0]        r_rreg, w_rmux;
  logic               w_in_sh, w_busy, w_wr, w_commit;
  logic               w_ctrl_sel, w_stat_sel;
  logic [IDX_W-1:0]   w_sh_idx;
  logic [COEF_W-1:0]  w_sh_rdata, w_cdata;

  assign w_in_sh    = (int'(avs_address) >= c_shadow_base) &&
                      (int'(avs_address) <  c_shadow_base + N_TAPS);
  assign w_sh_idx   = IDX_W'(int'(avs_address) - c_shadow_base);
  assign w_ctrl_sel = (avs_address == ADDR_W'(c_reg_ctrl));
  assign w_stat_sel = (avs_address == ADDR_W'(c_reg_status));
  assign w_busy     = (r_state == S_PEND) || (r_state == S_COPY);

  // Shadow writes are held off while the bank is being committed.
  assign avs_waitrequest = avs_write & w_in_sh & w_busy;
  assign w_wr            = avs_write & ~avs_waitrequest;
  assign w_commit        = w_wr & w_ctrl_sel & avs_byteenable[0] & avs_writedata[c_ctrl_commit];

  fir_coef_shadow #(.N_TAPS(N_TAPS), .COEF_W(COEF_W)) u_shadow (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_we    (w_wr & w_in_sh),
    .i_widx  (w_sh_idx),
    .i_wdata (avs_writedata),
    .i_be    (avs_byteenable),
    .i_re    (avs_read & w_in_sh),
    .i_ridx  (w_sh_idx),
    .o_rdata (w_sh_rdata),
    .i_cidx  (r_cnt),
    .o_cdata (w_cdata)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_commit) w_next = S_PEND;
      S_PEND:  if (sample_strobe) w_next = S_COPY;
      S_COPY:  if (r_cnt == IDX_W'(N_TAPS-1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      coef_we   <= 1'b0;
      coef_idx  <= '0;
      coef_data <= '0;
    end else begin
      r_state <= w_next;
      coef_we <= (r_state == S_COPY);
      if (r_state == S_COPY) begin
        coef_idx  <= r_cnt;
        coef_data <= w_cdata;
        r_cnt     <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_wr && w_ctrl_sel && avs_byteenable[0]) begin
        r_en     <= avs_writedata[c_ctrl_en];
        r_irq_en <= avs_writedata[c_ctrl_irq_en];
      end
      // Setting done takes priority over a simultaneous clear.
      if (r_state == S_DONE)
        r_done <= 1'b1;
      else if (w_wr && w_stat_sel && avs_byteenable[0] && avs_writedata[c_stat_done])
        r_done <= 1'b0;
    end
  end

`ifdef FIR_COEF_CHKSUM_EN
  logic [31:0] r_chk;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      r_chk <= '0;
    else if (r_state == S_PEND && sample_strobe)
      r_chk <= '0;
    else if (r_state == S_COPY)
      r_chk <= r_chk + 32'($signed(w_cdata));
  end
`endif

  always_comb begin
    w_rmux = '0;
    if (w_ctrl_sel) begin
      w_rmux[c_ctrl_en]     = r_en;
      w_rmux[c_ctrl_irq_en] = r_irq_en;
    end else if (w_stat_sel) begin
      w_rmux[c_stat_busy] = w_busy;
      w_rmux[c_stat_done] = r_done;
      w_rmux[c_stat_pend] = (r_state == S_PEND);
    end else if (avs_address == ADDR_W'(c_reg_ntaps)) begin
      w_rmux = 32'(N_TAPS);
`ifdef FIR_COEF_CHKSUM_EN
    end else if (avs_address == ADDR_W'(c_reg_chksum)) begin
      w_rmux = r_chk;
`endif
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdatavalid <= 1'b0;
      r_rsh             <= 1'b0;
      r_rreg            <= '0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        r_rsh  <= w_in_sh;
        r_rreg <= w_rmux;
      end
    end
  end

  assign avs_readdata = r_rsh ? 32'(w_sh_rdata) : r_rreg;
  assign fir_enable   = r_en;
  assign irq          = r_done & r_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_fir_coef_ctrl.sv
// +------------------------------------------------------------------+
// | tb_fir_coef_ctrl : scoreboard bench with a behavioural model of  |
// |                    the register map and the commit/copy stream.  |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_fir_coef_ctrl;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic        avs_waitrequest, avs_readdatavalid;
  logic [31:0] avs_readdata;
  logic        sample_strobe = 1'b0;
  logic        coef_we, fir_enable, irq;
  logic [3:0]  coef_idx;
  logic [15:0] coef_data;

  fir_coef_ctrl dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .sample_strobe(sample_strobe),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .fir_enable(fir_enable), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct { logic [31:0] d; int c; } rd_t;
  typedef struct { int idx; logic [15:0] d; } cf_t;
  rd_t rq[$];
  cf_t cq[$];

  // Behavioural model state
  logic [31:0] m_sh [N];
  bit          m_en, m_irq_en, m_done, m_busy, m_pend;
  logic [31:0] m_chk, m_chk_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (unexpected event)", name);
  endtask

  function automatic logic [31:0] mread(input int a);
    logic [31:0] v;
    v = '0;
    if (a == 0) v = {29'd0, m_irq_en, 1'b0, m_en};
    else if (a == 1) v = {29'd0, m_pend, m_done, m_busy};
    else if (a == 2) v = N;
`ifdef FIR_COEF_CHKSUM_EN
    else if (a == 3) v = m_chk;
`endif
    else if (a >= 'h100 && a < 'h100 + N) v = m_sh[a - 'h100];
    return v;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < N; t++) m_sh[t] = '0;
    m_en = 0; m_irq_en = 0; m_done = 0; m_busy = 0; m_pend = 0;
    m_chk = '0; m_chk_pend = '0;
    cq.delete();
    rq.delete();
  endtask

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] be);
    int sum;
    cf_t e;
    if (a >= 'h100 && a < 'h100 + N) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_sh[a - 'h100][8*b +: 8] = d[8*b +: 8];
      m_sh[a - 'h100] &= 32'h0000_FFFF;
    end else if (a == 0 && be[0]) begin
      m_en = d[0];
      m_irq_en = d[2];
      if (d[1] && !m_busy) begin
        m_busy = 1; m_pend = 1; sum = 0;
        for (int t = 0; t < N; t++) begin
          int v;
          e.idx = t; e.d = m_sh[t][15:0];
          cq.push_back(e);
          v = int'(m_sh[t][15:0]);
          if (v >= 32768) v -= 65536;
          sum += v;
        end
        m_chk_pend = sum;
      end
    end else if (a == 1 && be[0] && d[1]) begin
      m_done = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be, output int stalls);
    bit fin;
    avs_address = 10'(a); avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    stalls = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      if (!avs_waitrequest) fin = 1;
      else if (stalls > 200) begin fail("write_stall_timeout"); fin = 1; end
      else stalls++;
      @(posedge clk);
    end
    #1 avs_write = 1'b0;
    model_write(a, d, be);
  endtask

  task automatic w(input int a, input logic [31:0] d);
    int s;
    wr(a, d, 4'hF, s);
  endtask

  task automatic rd(input int a);
    rd_t e;
    e.d = mread(a); e.c = cyc + 1;
    rq.push_back(e);
    avs_address = 10'(a); avs_read = 1'b1;
    tick(1);
    avs_read = 1'b0;
  endtask

  task automatic strobe();
    sample_strobe = 1'b1;
    tick(1);
    sample_strobe = 1'b0;
    if (m_pend) m_pend = 0;
  endtask

  task automatic wait_done();
    tick(N + 4);
    if (m_busy && !m_pend) begin
      m_busy = 0; m_done = 1; m_chk = m_chk_pend;
    end
  endtask

  // Monitor: read-data and coefficient-stream scoreboard
  bit prev_we = 0;
  always @(negedge clk) begin
    rd_t r;
    cf_t c;
    if (rst_n && avs_readdatavalid) begin
      if (rq.size() == 0) fail("spurious_readdatavalid");
      else begin
        r = rq.pop_front();
        chk("rd_latency", cyc, r.c);
        chk("rd_data", avs_readdata, r.d);
      end
    end
    if (coef_we) begin
      if (cq.size() == 0) fail("extra_coef_we");
      else begin
        c = cq.pop_front();
        chk("coef_idx", 32'(coef_idx), c.idx);
        chk("coef_data", 32'(coef_data), 32'(c.d));
      end
    end else if (prev_we && cq.size() != 0) begin
      fail("coef_stream_gap");
    end
    prev_we = coef_we;
  end

  initial begin
    int st;
    bit hit;
    model_reset();
    tick(3);
    chk("rst_coef_we", 32'(coef_we), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_fir_enable", 32'(fir_enable), 0);
    chk("rst_readdata", avs_readdata, 0);
    rst_n = 1'b1;
    tick(1);
    rd(2); rd(1); rd(0); rd('h10A);

    // Ramp coefficients, commit with a coincident (ignored) strobe
    for (int k = 0; k < N; k++) w('h100 + k, k * 3);
    rd('h107);
    sample_strobe = 1'b1;
    w(0, 32'h6);
    sample_strobe = 1'b0;
    tick(3);
    rd(1);
    tick(1);
    strobe();
    wait_done();
    rd(1);
    tick(1);
    chk("irq_after_done", 32'(irq), 32'(m_done & m_irq_en));
    w(1, 32'h2);
    chk("irq_after_w1c", 32'(irq), 0);
    rd(0);

    // Shadow write during PEND stalls until the copy finishes
    w(0, 32'h6);
    fork
      wr('h105, 32'h7FFF, 4'hF, st);
      begin tick(4); strobe(); end
    join
    chk("pend_write_stalled", 32'(st >= N), 1);
    chk("copy_complete_at_release", cq.size(), 0);
    wait_done();
    rd('h105);
    w(1, 32'h2);

    // Commit while busy and stray strobes produce a single copy
    strobe();
    w(0, 32'h4);
    w(0, 32'h6);
    tick(2);
    strobe();
    tick(3);
    w(0, 32'h6);
    strobe(); strobe();
    wait_done();
    tick(3); strobe(); tick(3);
    chk("single_copy_drained", cq.size(), 0);
    rd(1);
    w(1, 32'h2);

    // Randomised rounds: partial byte enables, unmapped accesses, commit
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 6; k++) begin
        wr('h100 + $urandom_range(0, N-1), $urandom, 4'($urandom_range(0, 15)), st);
        rd('h100 + $urandom_range(0, N-1));
      end
      w('h050 + it, $urandom);
      rd('h050 + it);
      wr(0, 32'h7, 4'h0, st);
      rd(0);
      w(0, {29'd0, 1'($urandom), 1'b1, 1'($urandom)});
      chk("fir_enable", 32'(fir_enable), 32'(m_en));
      tick($urandom_range(0, 6));
      strobe();
      wait_done();
      rd(1); rd(3);
      tick(1);
      chk("irq_level", 32'(irq), 32'(m_done & m_irq_en));
      w(1, 32'h2);
    end

    // Reset in the middle of a copy
    for (int k = 0; k < N; k++) w('h100 + k, $urandom);
    w(0, 32'h6);
    tick(2);
    strobe();
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(posedge clk); #2;
      if (coef_we && coef_idx == 4'd7) hit = 1;
    end
    if (!hit) fail("copy_idx7_timeout");
    rst_n = 1'b0;
    #1;
    chk("reset_midcopy_coef_we", 32'(coef_we), 0);
    chk("reset_midcopy_irq", 32'(irq), 0);
    model_reset();
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    rd(1); rd('h103); rd(0);

    // All-ones coefficients: checksum is -16 when the feature is built
    for (int k = 0; k < N; k++) w('h100 + k, 32'hFFFF);
    w(0, 32'h2);
    tick(1);
    strobe();
    wait_done();
    rd(3);
    tick(3);
    chk("read_queue_drained", rq.size(), 0);
    chk("coef_queue_drained", cq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
